// File: rtl/mem_mapper_pkg.sv
// Shared definitions for the memory mapper: register offsets, control bit positions, page reset values.
// Optional write-protect support is enabled with the MEM_MAPPER_WPROT_EN macro.
package mem_mapper_pkg;

    localparam int PAGE_BITS = 4;
    localparam int NUM_PAGES = 4;

    typedef enum logic [2:0] {
        REG_PAGE0 = 3'd0,
        REG_PAGE1 = 3'd1,
        REG_PAGE2 = 3'd2,
        REG_PAGE3 = 3'd3,
        REG_CTRL  = 3'd4,
        REG_NONE  = 3'd7
    } reg_sel_t;

    localparam logic [7:0] OFS_CTRL = 8'd4;

    localparam int MAP_EN  = 0;
    localparam int ROM_EN  = 1;
    localparam int WP_VIOL = 7;
    localparam int WP_BIT  = 7;

    function automatic logic [PAGE_BITS-1:0] reset_page(input int idx);
        return PAGE_BITS'(idx);
    endfunction

    // Offsets below the base wrap to large values and fall through to REG_NONE.
    function automatic reg_sel_t decode_reg(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] ofs;
        ofs = addr - base;
        if (ofs <= OFS_CTRL)
            return reg_sel_t'(ofs[2:0]);
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_mapper_if.sv
// CPU-side and SRAM-side bus signals of the memory mapper, grouped for the CPU (master) and mapper (slave).
interface mem_mapper_if;
    logic [15:0] cpuAddress;
    logic [7:0]  dataIn;
    logic        n_ioWR;
    logic        n_ioRD;
    logic        n_memWR;
    logic        n_memRD;
    logic [7:0]  dataOut;
    logic        n_mapperCS;
    logic        n_basRomCS;
    logic [17:0] sramAddress;
    logic        n_sRamCS;
    logic        n_sRamWE;
    logic        n_sRamOE;

    modport master (
        output cpuAddress, dataIn, n_ioWR, n_ioRD, n_memWR, n_memRD,
        input  dataOut, n_mapperCS, n_basRomCS, sramAddress, n_sRamCS, n_sRamWE, n_sRamOE
    );

    modport slave (
        input  cpuAddress, dataIn, n_ioWR, n_ioRD, n_memWR, n_memRD,
        output dataOut, n_mapperCS, n_basRomCS, sramAddress, n_sRamCS, n_sRamWE, n_sRamOE
    );
endinterface

// File: rtl/mem_mapper_bus_strobe_edge.sv
// Registers an active-low bus strobe and emits single-cycle rise/fall pulses.
module bus_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic rise,
    output logic fall
);
    logic strobe_q_reg;

    always_ff @(posedge clk) begin
        if (reset)
            strobe_q_reg <= 1'b1;
        else
            strobe_q_reg <= strobe;
    end

    assign rise = ~strobe_q_reg &  strobe;
    assign fall =  strobe_q_reg & ~strobe;
endmodule

// File: rtl/mem_mapper.sv
// Paged SRAM mapper with ROM enable control and register read-back for the tv80 bus.
// Define MEM_MAPPER_WPROT_EN to add per-page write protect and a sticky violation flag.
module mem_mapper
    import mem_mapper_pkg::*;
#(
    parameter logic [7:0] IO_BASE      = 8'h78,
    parameter logic [7:0] ROM_OFF_PORT = 8'h38,
    parameter int         ROM_TOP      = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_mapper_if.slave  bus
);
    logic [PAGE_BITS-1:0] page_reg [NUM_PAGES];
    logic [7:0]           page_rd  [NUM_PAGES];
    logic                 map_en_reg;
    logic                 rom_en_reg;
    logic [7:0]           shadow_addr_reg;
    logic [7:0]           shadow_data_reg;
    logic                 idle_seen_reg;
    logic                 pending_reg;
    logic                 wr_rise;
    logic                 wr_fall;
    logic                 commit;
    logic                 wp_viol;
    logic                 we_block;
    reg_sel_t             commit_sel;
    reg_sel_t             read_sel;
    logic [PAGE_BITS-1:0] cur_page;
    logic [7:0]           ctrl_rd;

    bus_strobe_edge u_io_wr_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (bus.n_ioWR),
        .rise   (wr_rise),
        .fall   (wr_fall)
    );

    // A write is armed only by a falling edge seen after the strobe was idle since reset,
    // so a strobe already low across reset never commits on its release.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_addr_reg <= 8'h00;
            shadow_data_reg <= 8'h00;
            idle_seen_reg   <= 1'b0;
            pending_reg     <= 1'b0;
        end else begin
            if (!bus.n_ioWR) begin
                shadow_addr_reg <= bus.cpuAddress[7:0];
                shadow_data_reg <= bus.dataIn;
            end else begin
                idle_seen_reg <= 1'b1;
            end
            if (commit)
                pending_reg <= 1'b0;
            else if (wr_fall && idle_seen_reg)
                pending_reg <= 1'b1;
        end
    end

    assign commit     = wr_rise & pending_reg;
    assign commit_sel = decode_reg(shadow_addr_reg, IO_BASE);
    assign read_sel   = decode_reg(bus.cpuAddress[7:0], IO_BASE);

`ifdef MEM_MAPPER_WPROT_EN
    logic page_wp_reg [NUM_PAGES];
    logic wp_viol_reg;
    logic mem_wr_rise;
    logic mem_wr_fall;
`endif

    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
        always_ff @(posedge clk) begin
            if (reset)
                page_reg[gi] <= reset_page(gi);
            else if (commit && commit_sel == reg_sel_t'(3'(gi)))
                page_reg[gi] <= shadow_data_reg[PAGE_BITS-1:0];
        end
`ifdef MEM_MAPPER_WPROT_EN
        always_ff @(posedge clk) begin
            if (reset)
                page_wp_reg[gi] <= 1'b0;
            else if (commit && commit_sel == reg_sel_t'(3'(gi)))
                page_wp_reg[gi] <= shadow_data_reg[WP_BIT];
        end
        assign page_rd[gi] = {page_wp_reg[gi], 3'b000, page_reg[gi]};
`else
        assign page_rd[gi] = {4'b0000, page_reg[gi]};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            map_en_reg <= 1'b0;
            rom_en_reg <= 1'b1;
        end else if (commit) begin
            if (commit_sel == REG_CTRL) begin
                map_en_reg <= shadow_data_reg[MAP_EN];
                rom_en_reg <= shadow_data_reg[ROM_EN];
            end
            if (shadow_addr_reg == ROM_OFF_PORT)
                rom_en_reg <= 1'b0;
        end
    end

`ifdef MEM_MAPPER_WPROT_EN
    bus_strobe_edge u_mem_wr_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (bus.n_memWR),
        .rise   (mem_wr_rise),
        .fall   (mem_wr_fall)
    );

    // A violation arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (reset)
            wp_viol_reg <= 1'b0;
        else if (mem_wr_fall && we_block)
            wp_viol_reg <= 1'b1;
        else if (commit && commit_sel == REG_CTRL && shadow_data_reg[WP_VIOL])
            wp_viol_reg <= 1'b0;
    end

    assign we_block = map_en_reg & page_wp_reg[bus.cpuAddress[15:14]];
    assign wp_viol  = wp_viol_reg;
    logic unused_wprot;
    assign unused_wprot = &{1'b0, mem_wr_rise, shadow_data_reg[6:4]};
`else
    assign we_block = 1'b0;
    assign wp_viol  = 1'b0;
    logic unused_wprot;
    assign unused_wprot = &{1'b0, shadow_data_reg[7:4]};
`endif

    assign ctrl_rd  = {wp_viol, 5'b00000, rom_en_reg, map_en_reg};
    assign cur_page = page_reg[bus.cpuAddress[15:14]];

    always_comb begin
        bus.dataOut = 8'hFF;
        case (read_sel)
            REG_PAGE0, REG_PAGE1, REG_PAGE2, REG_PAGE3: bus.dataOut = page_rd[read_sel[1:0]];
            REG_CTRL:                                   bus.dataOut = ctrl_rd;
            default:                                    bus.dataOut = 8'hFF;
        endcase
    end

    assign bus.n_mapperCS  = ~((read_sel != REG_NONE) & (~bus.n_ioWR | ~bus.n_ioRD));
    assign bus.n_basRomCS  = ~((bus.cpuAddress[15 -: ROM_TOP] == '0) & rom_en_reg);
    assign bus.n_sRamCS    = ~bus.n_basRomCS;
    assign bus.sramAddress = map_en_reg ? {cur_page, bus.cpuAddress[13:0]}
                                        : {2'b00, bus.cpuAddress};
    assign bus.n_sRamOE    = bus.n_memRD | bus.n_sRamCS;
    assign bus.n_sRamWE    = bus.n_memWR | bus.n_sRamCS | we_block;
endmodule
